// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states and instruction-format widths.
// Imported by the fetch unit, its next-PC calculator and its bus interface.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_DROP
    } fetch_state_t;

    localparam int INST_BYTES = 4;
    localparam int J_IDX_W    = 26;
    localparam int BR_IMM_W   = 16;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: imem req/ack port plus the decode valid/ready port
// with the branch/jump redirect that decode returns along with each accept.
// master = fetch unit side, slave = memory/decode side.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    import cpu_pkg::*;

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_ack;
    logic [INST_W-1:0]   imem_rdata;

    logic                inst_valid;
    logic                inst_ready;
    logic [INST_W-1:0]   inst;
    logic [ADDR_W-1:0]   inst_pc;

    logic                br_taken;
    logic [BR_IMM_W-1:0] br_imm;
    logic                jmp;
    logic [J_IDX_W-1:0]  jmp_idx;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  br_taken, br_imm, jmp, jmp_idx
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output br_taken, br_imm, jmp, jmp_idx
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC: sequential, PC-relative branch or region jump.
// Ports: inst_pc, br_taken, br_imm, jmp, jmp_idx in; next_pc out.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]   inst_pc,
    input  logic                br_taken,
    input  logic [BR_IMM_W-1:0] br_imm,
    input  logic                jmp,
    input  logic [J_IDX_W-1:0]  jmp_idx,
    output logic [ADDR_W-1:0]   next_pc
);

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_tgt;

    assign pc4 = inst_pc + ADDR_W'(INST_BYTES);

    // word offset, sign-extended then scaled to bytes
    assign br_off = {{(ADDR_W-BR_IMM_W-2){br_imm[BR_IMM_W-1]}},
                     br_imm, 2'b00};

    // jump keeps the region bits above bit 27 of pc4 (none when ADDR_W=28)
    always_comb begin
        jmp_tgt = pc4;
        jmp_tgt[J_IDX_W+1:0] = {jmp_idx, 2'b00};
    end

    always_comb begin
        next_pc = pc4;
        if (jmp) begin
            next_pc = jmp_tgt;
        end else if (br_taken) begin
            next_pc = pc4 + br_off;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction fetch front end.
// Ports: clk, reset (sync, active-high), halt, flush/flush_pc redirect,
// fetch_cnt (accepted instructions), bus = imem + decode bundle (master).
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [CNT_W-1:0]  fetch_cnt,
    pc_fetch_unit_if.master   bus
);

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [ADDR_W-1:0] drop_addr, drop_addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] next_pc;
    fetch_state_t      resume;
    logic              accept;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_next (
        .inst_pc  (inst_pc_q),
        .br_taken (bus.br_taken),
        .br_imm   (bus.br_imm),
        .jmp      (bus.jmp),
        .jmp_idx  (bus.jmp_idx),
        .next_pc  (next_pc)
    );

    assign bus.imem_req   = (state == ST_REQ) || (state == ST_DROP);
    // an abandoned request must finish on the address it was issued with
    assign bus.imem_addr  = (state == ST_DROP) ? drop_addr : pc;
    assign bus.inst_valid = (state == ST_HOLD);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign fetch_cnt      = cnt;

    assign accept = bus.inst_valid && bus.inst_ready;
    assign resume = halt ? ST_IDLE : ST_REQ;

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        drop_addr_d = drop_addr;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        cnt_d       = cnt;
        if (flush) begin
            pc_d = flush_pc;
            unique case (state)
                ST_IDLE, ST_HOLD: state_d = resume;
                ST_REQ: begin
                    if (bus.imem_ack) begin
                        state_d = resume;
                    end else begin
                        state_d     = ST_DROP;
                        drop_addr_d = pc;
                    end
                end
                ST_DROP: begin
                    if (bus.imem_ack) begin
                        state_d = resume;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state)
                ST_IDLE: state_d = resume;
                ST_REQ: begin
                    if (bus.imem_ack) begin
                        inst_d    = bus.imem_rdata;
                        inst_pc_d = pc;
                        state_d   = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        pc_d    = next_pc;
                        cnt_d   = cnt + 1'b1;
                        state_d = resume;
                    end
                end
                ST_DROP: begin
                    if (bus.imem_ack) begin
                        state_d = resume;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= RESET_PC;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            drop_addr <= drop_addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// fetch stream checked against a transaction-level PC/memory model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        flush;
    logic [31:0] flush_pc;
    logic [15:0] fetch_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;

    pc_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

    pc_fetch_unit #(
        .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0), .CNT_W(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .halt      (halt),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .fetch_cnt (fetch_cnt),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    // next PC from the ISA rules: region jump, word-offset branch, or +4
    function automatic logic [31:0] ref_next(input logic [31:0] pc,
                                             input logic br,
                                             input logic [15:0] imm,
                                             input logic j,
                                             input logic [25:0] idx);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
        off = int'($signed(imm));
        if (br) return seq + 32'(off * 4);
        return seq;
    endfunction

    // one full fetch: wait for req, ack after d cycles, stall s cycles, accept
    task automatic do_fetch(input int d, input int s, input logic br,
                            input logic [15:0] imm, input logic j,
                            input logic [25:0] idx, input logic h);
        int          n;
        logic [31:0] w;
        n = 0;
        halt = 1'b0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout got req=%b exp 1", bus.imem_req);
            return;
        end
        checks++;
        if (bus.imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL req_addr got %h exp %h", bus.imem_addr, exp_pc);
        end
        for (int i = 0; i < d; i++) begin
            bus.imem_ack = 1'b0;
            halt = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_hold got req=%b addr=%h exp 1 %h",
                         bus.imem_req, bus.imem_addr, exp_pc);
            end
        end
        w = mem_word(exp_pc);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = w;
        tick();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== w ||
            bus.inst_pc !== exp_pc || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL deliver got v=%b inst=%h pc=%h req=%b exp 1 %h %h 0",
                     bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req,
                     w, exp_pc);
        end
        for (int i = 0; i < s; i++) begin
            bus.inst_ready = 1'b0;
            bus.br_taken = 1'($urandom_range(0, 1));
            bus.jmp = 1'($urandom_range(0, 1));
            halt = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst !== w ||
                bus.inst_pc !== exp_pc) begin
                errors++;
                $display("FAIL stall got v=%b inst=%h pc=%h exp 1 %h %h",
                         bus.inst_valid, bus.inst, bus.inst_pc, w, exp_pc);
            end
        end
        bus.inst_ready = 1'b1;
        bus.br_taken = br;
        bus.br_imm = imm;
        bus.jmp = j;
        bus.jmp_idx = idx;
        halt = h;
        tick();
        bus.inst_ready = 1'b0;
        bus.br_taken = 1'b0;
        bus.jmp = 1'b0;
        exp_pc = ref_next(exp_pc, br, imm, j, idx);
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (fetch_cnt !== exp_cnt || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept got cnt=%0d v=%b exp %0d 0",
                     fetch_cnt, bus.inst_valid, exp_cnt);
        end
        checks++;
        if (bus.imem_req !== !h || bus.imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL next_req got req=%b addr=%h exp %b %h",
                     bus.imem_req, bus.imem_addr, !h, exp_pc);
        end
        if (h) begin
            for (int i = 0; i < 2; i++) begin
                tick();
                checks++;
                if (bus.imem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL halt_idle got req=%b exp 0", bus.imem_req);
                end
            end
            halt = 1'b0;
            tick();
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL unhalt got req=%b addr=%h exp 1 %h",
                         bus.imem_req, bus.imem_addr, exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        halt = 1'b0;
        flush = 1'b1;
        flush_pc = 32'h0000_0100;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.inst_ready = 1'b1;
        bus.br_taken = 1'b0;
        bus.br_imm = '0;
        bus.jmp = 1'b0;
        bus.jmp_idx = '0;
        repeat (3) tick();
        checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 ||
            bus.inst_valid !== 1'b0 || bus.inst !== 32'h0 ||
            bus.inst_pc !== 32'h0 || fetch_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset got req=%b addr=%h v=%b inst=%h pc=%h cnt=%0d exp all 0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst,
                     bus.inst_pc, fetch_cnt);
        end
        reset = 1'b0;
        flush = 1'b0;
        bus.imem_ack = 1'b0;
        bus.inst_ready = 1'b0;
        exp_pc = 32'h0;
        exp_cnt = 16'h0;
        tick();
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL idle_to_req got req=%b addr=%h exp 1 0",
                     bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_seq();
        for (int i = 0; i < 4; i++) begin
            do_fetch(0, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
        end
        checks++;
        if (fetch_cnt !== 16'd4 || bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL seq got cnt=%0d addr=%h exp 4 00000010",
                     fetch_cnt, bus.imem_addr);
        end
    endtask

    task automatic test_branch();
        do_fetch(0, 0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0);
        do_fetch(0, 0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h3C) begin
            errors++;
            $display("FAIL br_back got %h exp 0000003c", bus.imem_addr);
        end
        do_fetch(0, 0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0);
        do_fetch(0, 0, 1'b1, 16'h0003, 1'b0, 26'h0, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h50) begin
            errors++;
            $display("FAIL br_fwd got %h exp 00000050", bus.imem_addr);
        end
    endtask

    task automatic test_jump();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(exp_pc);
        tick();
        bus.imem_ack = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL jump_hold got v=%b exp 1", bus.inst_valid);
        end
        flush = 1'b1;
        flush_pc = 32'h1000_0010;
        bus.inst_ready = 1'b1;
        tick();
        flush = 1'b0;
        bus.inst_ready = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
            bus.imem_addr !== 32'h1000_0010 || fetch_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL flush_hold got v=%b req=%b addr=%h cnt=%0d exp 0 1 10000010 %0d",
                     bus.inst_valid, bus.imem_req, bus.imem_addr, fetch_cnt,
                     exp_cnt);
        end
        exp_pc = 32'h1000_0010;
        do_fetch(0, 0, 1'b0, 16'h0, 1'b1, 26'h100, 1'b0);
        checks++;
        if (bus.imem_addr !== 32'h1000_0400) begin
            errors++;
            $display("FAIL jmp got %h exp 10000400", bus.imem_addr);
        end
    endtask

    task automatic test_stall();
        do_fetch(3, 5, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
    endtask

    task automatic test_flush_drop();
        logic [31:0] old;
        old = exp_pc;
        flush = 1'b1;
        flush_pc = 32'h70;
        tick();
        flush = 1'b0;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== old) begin
            errors++;
            $display("FAIL drop_enter got req=%b addr=%h exp 1 %h",
                     bus.imem_req, bus.imem_addr, old);
        end
        tick();
        flush = 1'b1;
        flush_pc = 32'h80;
        tick();
        flush = 1'b0;
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== old ||
            bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_hold got req=%b addr=%h v=%b exp 1 %h 0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid, old);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.imem_ack = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
            bus.imem_addr !== 32'h80 || fetch_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL drop_done got v=%b req=%b addr=%h cnt=%0d exp 0 1 00000080 %0d",
                     bus.inst_valid, bus.imem_req, bus.imem_addr, fetch_cnt,
                     exp_cnt);
        end
        exp_pc = 32'h80;
        do_fetch(1, 0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
    endtask

    task automatic test_wrap_halt();
        flush = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hBAD1_BAD1;
        tick();
        flush = 1'b0;
        bus.imem_ack = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 ||
            bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL flush_ack got v=%b req=%b addr=%h exp 0 1 fffffffc",
                     bus.inst_valid, bus.imem_req, bus.imem_addr);
        end
        exp_pc = 32'hFFFF_FFFC;
        do_fetch(0, 1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1);
        checks++;
        if (bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap got %h exp 00000000", bus.imem_addr);
        end
    endtask

    task automatic test_random();
        logic        br, j, h;
        logic [15:0] imm;
        logic [25:0] idx;
        for (int k = 0; k < 40; k++) begin
            br  = ($urandom_range(0, 2) == 0);
            j   = ($urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 4) == 0);
            imm = 16'($urandom);
            idx = 26'($urandom);
            do_fetch($urandom_range(0, 3), $urandom_range(0, 3),
                     br, imm, j, idx, h);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_stall();
        test_flush_drop();
        test_wrap_halt();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
